// File: rtl/number_composer.sv
// number_composer: rebuilds a WIDTH-bit value as quotient*divisor + remainder
// (divisor 3 or 4) by repeated addition under a four-state FSM. The result is
// reported with its parity, a remainder-range error and 8-bit overflow.
module number_composer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] quotient,
  input  logic [2:0]       remainder,
  input  logic             divisor_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] number,
  output logic             odd,
  output logic             overflow,
  output logic             rem_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    ACCUM  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state_q, state_d;

  // acc is two bits wider than the result so 255*4+3 never wraps internally.
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]       div_q, div_d;
  logic [2:0]       rem_q, rem_d;
  logic             err_q, err_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] number_q, number_d;
  logic             odd_q, odd_d;
  logic             overflow_q, overflow_d;
  logic             rem_err_q, rem_err_d;

  // Next-state and datapath: every register holds unless its state updates it.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    rem_d      = rem_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    number_d   = number_q;
    odd_d      = odd_q;
    overflow_d = overflow_q;
    rem_err_d  = rem_err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = quotient;
          rem_d   = remainder;
          div_d   = divisor_sel ? 3'd4 : 3'd3;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (rem_q >= div_q) begin
          err_d   = 1'b1;
          acc_d   = '0;
          state_d = FINISH;
        end else begin
          err_d   = 1'b0;
          acc_d   = {{(WIDTH-1){1'b0}}, rem_q};
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (cnt_q != '0) begin
          acc_d = acc_q + {{(WIDTH-1){1'b0}}, div_q};
          cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        number_d   = acc_q[WIDTH-1:0];
        odd_d      = acc_q[0];
        overflow_d = (acc_q[WIDTH+1:WIDTH] != 2'b00);
        rem_err_d  = err_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      div_q      <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      number_q   <= '0;
      odd_q      <= 1'b0;
      overflow_q <= 1'b0;
      rem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      number_q   <= number_d;
      odd_q      <= odd_d;
      overflow_q <= overflow_d;
      rem_err_q  <= rem_err_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign number   = number_q;
  assign odd      = odd_q;
  assign overflow = overflow_q;
  assign rem_err  = rem_err_q;

endmodule

// File: tb/tb_number_composer.sv
// Testbench for number_composer: scoreboard of expected results pushed at the
// start-sampling edge and popped when done pulses.
module tb_number_composer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] quotient = 8'd0;
  logic [2:0] remainder = 3'd0;
  logic       divisor_sel = 1'b0;
  logic       busy, done, odd, overflow, rem_err;
  logic [7:0] number;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         q;
    int         d;
    int         r;
    logic [7:0] num;
    logic       odd;
    logic       ovf;
    logic       err;
    int         lat;
    int         start_cyc;
  } exp_t;

  exp_t sb[$];

  number_composer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .quotient(quotient),
    .remainder(remainder), .divisor_sel(divisor_sel), .busy(busy),
    .done(done), .number(number), .odd(odd), .overflow(overflow),
    .rem_err(rem_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Build the expected result for one operation from the arithmetic itself.
  function automatic exp_t make_exp(input int q, input int d, input int r, input int sc);
    exp_t e;
    int full;
    e.q = q; e.d = d; e.r = r; e.start_cyc = sc;
    if (r >= d) begin
      e.num = 8'd0; e.odd = 1'b0; e.ovf = 1'b0; e.err = 1'b1; e.lat = 2;
    end else begin
      full  = q * d + r;
      e.num = full[7:0]; e.odd = full[0]; e.ovf = (full > 255);
      e.err = 1'b0; e.lat = q + 3;
    end
    return e;
  endfunction

  // Monitor: pop the oldest expectation on every done pulse and compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = sb.pop_front();
        $display("op q=%0d d=%0d r=%0d -> number=%0d odd=%0b ovf=%0b err=%0b lat=%0d",
                 e.q, e.d, e.r, number, odd, overflow, rem_err, cyc - e.start_cyc);
        if (number !== e.num) begin
          bad++;
          $display("FAIL number: got %0d required %0d", number, e.num);
        end
        total++;
        if (odd !== e.odd) begin
          bad++;
          $display("FAIL odd: got %0b required %0b", odd, e.odd);
        end
        total++;
        if (overflow !== e.ovf) begin
          bad++;
          $display("FAIL overflow: got %0b required %0b", overflow, e.ovf);
        end
        total++;
        if (rem_err !== e.err) begin
          bad++;
          $display("FAIL rem_err: got %0b required %0b", rem_err, e.err);
        end
        total++;
        if ((cyc - e.start_cyc) != e.lat) begin
          bad++;
          $display("FAIL latency: got %0d required %0d", cyc - e.start_cyc, e.lat);
        end
        // Round trip through a classifier model: number mod divisor gives r back.
        if (e.err == 1'b0 && e.ovf == 1'b0) begin
          total++;
          if ((int'(number) % e.d) != e.r) begin
            bad++;
            $display("FAIL round_trip: number %0d mod %0d = %0d required %0d",
                     number, e.d, int'(number) % e.d, e.r);
          end
        end
      end
    end
  end

  // Present one operation while the DUT is idle; expectation queued at E0.
  task automatic issue(input int q, input int d, input int r);
    @(negedge clk);
    quotient    = q[7:0];
    remainder   = r[2:0];
    divisor_sel = (d == 4);
    start       = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(make_exp(q, d, r, cyc));
    start = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding after %0d cycles, required 0",
               sb.size(), bound);
      sb.delete();
    end
  endtask

  task automatic test_reset;
    int busy_seen = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, number, odd, overflow, rem_err} !== 13'd0) begin
      bad++;
      $display("FAIL reset_state: outputs=%h required 0",
               {busy, done, number, odd, overflow, rem_err});
    end
    @(negedge clk);
    rst = 1'b1;
    issue(50, 3, 0);
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    total++;
    if ({busy, done, number, odd, overflow, rem_err} !== 13'd0) begin
      bad++;
      $display("FAIL async_reset: outputs=%h required 0 immediately",
               {busy, done, number, odd, overflow, rem_err});
    end
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) busy_seen++;
    end
    total++;
    if (busy_seen != 0) begin
      bad++;
      $display("FAIL idle_after_reset: busy high %0d cycles, required 0", busy_seen);
    end
    $display("reset mid-operation: busy cycles after release=%0d", busy_seen);
  endtask

  task automatic test_basic_d3;
    int n = 0;
    issue(5, 3, 2);
    while (busy === 1'b1 && n < 300) begin
      n++;
      @(posedge clk);
      #1;
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL busy_length: got %0d cycles required 8", n);
    end
    wait_drain(20);
  endtask

  task automatic test_d4_zero_q;
    issue(0, 4, 3);
    wait_drain(20);
    issue(63, 4, 0);
    wait_drain(100);
  endtask

  task automatic test_rem_err;
    issue(10, 3, 3);
    wait_drain(20);
    issue(1, 4, 4);
    wait_drain(20);
    issue(1, 4, 3);
    wait_drain(20);
  endtask

  task automatic test_overflow;
    issue(255, 4, 3);
    wait_drain(400);
    issue(85, 3, 0);
    wait_drain(200);
  endtask

  // start held high; operands scrambled while busy and set to the next real
  // operation in the cycle done is high, which is when it must be accepted.
  task automatic test_back_to_back;
    int ops_q[5] = '{7, 0, 20, 3, 12};
    int ops_d[5] = '{3, 4, 4, 3, 4};
    int ops_r[5] = '{1, 2, 5, 2, 3};
    int idx = 0;
    int guard = 0;
    @(negedge clk);
    quotient = ops_q[0][7:0]; remainder = ops_r[0][2:0];
    divisor_sel = (ops_d[0] == 4); start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(make_exp(ops_q[0], ops_d[0], ops_r[0], cyc));
    idx = 1;
    while (idx <= 5 && guard < 500) begin
      guard++;
      if (done === 1'b1) begin
        if (idx == 5) begin
          start = 1'b0;
          idx++;
        end else begin
          quotient = ops_q[idx][7:0]; remainder = ops_r[idx][2:0];
          divisor_sel = (ops_d[idx] == 4);
          @(posedge clk);
          #1;
          sb.push_back(make_exp(ops_q[idx], ops_d[idx], ops_r[idx], cyc));
          idx++;
          continue;
        end
      end else begin
        quotient = 8'($urandom); remainder = 3'($urandom);
        divisor_sel = 1'($urandom);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    total++;
    if (idx <= 5) begin
      bad++;
      $display("FAIL back_to_back: issued %0d of 5 operations", idx);
    end
    wait_drain(100);
  endtask

  task automatic test_round_trip;
    for (int q = 0; q <= 60; q++) begin
      for (int r = 0; r < 3; r++) begin
        issue(q, 3, r);
        wait_drain(100);
      end
      for (int r = 0; r < 4; r++) begin
        issue(q, 4, r);
        wait_drain(100);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_d3();
    test_d4_zero_q();
    test_rem_err();
    test_overflow();
    test_back_to_back();
    test_round_trip();
    repeat (5) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/number_composer.md
Name: number_composer

Overview:
- Sequential inverse of the divisibility classifier: rebuilds an 8-bit number as quotient*divisor + remainder, with divisor 3 or 4.
- Uses repeated addition under a small FSM.
- Sits beside the classifier so a bench or the top level can generate operands and loop them back for round-trip checks.
- Reports parity, remainder-range errors and overflow of the 8-bit result.

Parameters:
- WIDTH, 8, width of quotient and result.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low: 0 resets all state immediately.
- start  input  1  request; sampled only in IDLE.
- quotient  input  WIDTH  multiplier operand.
- remainder  input  3  addend; must be less than the divisor.
- divisor_sel  input  1  0 selects divisor 3, 1 selects divisor 4.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results are valid.
- number  output  WIDTH  composed result, low WIDTH bits.
- odd  output  1  number[0] of the result.
- overflow  output  1  true result exceeded 2^WIDTH-1.
- rem_err  output  1  remainder was not less than the divisor.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - busy, done, number, odd, overflow and rem_err all 0.
  - Internal acc, cnt, div and rem registers cleared.
  - Reset mid-operation aborts with no done pulse.
- Internal registers:
  - acc: WIDTH+2 bits (max 255*4+3 = 1023, no internal wrap).
  - cnt: WIDTH bits.
  - div: 3 bits.
  - rem: 3 bits.
- IDLE: at edge E0, if start=1:
  - latch quotient into cnt, remainder into rem, and 3 or 4 into div;
  - busy<=1;
  - go to CHECK.
  - start=0 stays in IDLE.
  - start while busy is ignored; inputs are not re-sampled until IDLE.
- CHECK (edge E1):
  - if rem >= div: rem_err flagged internally, acc<=0, go to FINISH;
  - else acc<=rem, go to ACCUM.
- ACCUM:
  - each edge with cnt!=0: acc<=acc+div, cnt<=cnt-1.
  - edge with cnt==0: go to FINISH.
  - q additions take edges E2..E(q+1); transition to FINISH at E(q+2).
- FINISH (edge E(q+3)), all outputs registered:
  - number<=acc[WIDTH-1:0];
  - odd<=acc[0];
  - overflow<=(acc[WIDTH+1:WIDTH]!=0);
  - rem_err<=internal flag;
  - done<=1; busy<=0; state<=IDLE.
- done falls at the next edge. Results hold until the next FINISH.
- Latency from start-sampling edge to done rising:
  - normal path: q+3 edges;
  - rem_err path: 2 edges (CHECK→FINISH at E1, done at E2).
- On rem_err: number=0, odd=0, overflow=0.
- Overflow: number carries the wrapped low WIDTH bits; overflow=1 for that result only (not sticky across operations).
- start may be asserted in the cycle done is high: the FSM is already in IDLE, so it is accepted at that edge. Back-to-back operations have one done pulse each.
- q=0 is legal: no additions; result=remainder.
- divisor_sel and operand changes during busy have no effect on the current operation.
- FSM states: IDLE, CHECK, ACCUM, FINISH. Any unused encoding returns to IDLE.

Test Plan:
- Reset mid-operation:
  - Stimulus: rst=0 for 2 cycles, release, then start with q=50, d=3, r=0; assert rst=0 at cycle 10.
  - Required: all outputs 0 immediately, no done pulse; after release, IDLE with busy=0.
- Basic compose, divisor 3:
  - Stimulus: q=5, d=3, r=2.
  - Required: done rises exactly 8 edges after start is sampled; number=17, odd=1, overflow=0, rem_err=0; busy high for exactly 8 cycles.
- Basic compose, divisor 4, zero quotient:
  - Stimulus: q=0, d=4, r=3, then q=63, d=4, r=0.
  - Required: first: number=3, odd=1, done 3 edges after start. Second: number=252, odd=0, done 66 edges after start.
- Remainder error:
  - Stimulus: q=10, d=3, r=3.
  - Required: done 2 edges after start; rem_err=1, number=0, overflow=0.
  - Then q=1, d=4, r=4: rem_err=1. Then r=3: rem_err=0, number=7.
- Overflow:
  - Stimulus: q=255, d=4, r=3.
  - Required: done after 258 edges; overflow=1, number=1023 mod 256 = 255, odd=1.
  - Next op q=85, d=3, r=0: number=255, overflow=0.
- Handshake and round-trip:
  - Stimulus: start held high continuously with operands changed while busy; then loop each number into the classifier.
  - Required: operations run back-to-back, one done per operation, mid-operation operand changes ignored.
  - Required round trip: for d=3, the classifier's rem_3 equals r; for d=4, its rem_4 equals r; over all q<=60 and all legal r.
